// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   scan_state_e    : scanner FSM state encoding
//   RowPat          : one-hot-low row drive pattern, indexed by row number
//   KeyMap          : raw key index (row*4 + col) to hex digit, for calculator operand entry
//   key_to_hex      : KeyMap lookup helper
//   lowest_low_col  : priority pick of the lowest-numbered active-low column
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } scan_state_e;

  localparam logic [3:0][3:0] RowPat = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Standard phone-style layout; '*' maps to E and '#' to F.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D
  localparam logic [15:0][3:0] KeyMap = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_to_hex(input logic [3:0] idx);
    return KeyMap[idx];
  endfunction

  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    if (!cols[0]) return 2'd0;
    if (!cols[1]) return 2'd1;
    if (!cols[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d_i   : asynchronous input bus
//   q_o   : synchronized output bus
module sync2 #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with slot-based debounce.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   col_in    : matrix columns, active-low, asynchronous
//   row_out   : one-hot-low row drive
//   key_valid : one-cycle pulse per accepted press
//   key_code  : raw key index row*4 + col, held until the next accepted press
//   key_held  : high while the accepted key stays pressed
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [DivW-1:0] DivLast    = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(DEBOUNCE_TICKS - 1);
  localparam logic [CntW-1:0] IdleLast   = CntW'(DEBOUNCE_TICKS);

  logic [3:0]      col_sync;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  scan_state_e     state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;

  sync2 #(
    .Width(4)
  ) u_sync2 (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (col_in),
    .q_o  (col_sync)
  );

  assign tick  = (div_q == DivLast);
  assign div_d = tick ? '0 : div_q + DivW'(1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    cnt_inc    = cnt_q + CntW'(1);

    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (col_sync != 4'hF) begin
            // Row index stays frozen; it is the candidate row.
            cand_col_d = lowest_low_col(col_sync);
            cnt_d      = '0;
            state_d    = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        StDebounce: begin
          if (!col_sync[cand_col_q]) begin
            if (cnt_inc >= StableLast) begin
              code_d  = {row_q, cand_col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StScan;
            row_d   = row_q + 2'd1;
          end
        end
        StHeld: begin
          if (col_sync[cand_col_q]) begin
            cnt_d   = CntW'(1);
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (col_sync[cand_col_q]) begin
            if (cnt_inc == IdleLast) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = StScan;
              row_d   = row_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Bounce during release: back to held without a new pulse.
            state_d = StHeld;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      state_q    <= StScan;
      row_q      <= 2'd0;
      cand_col_q <= 2'd0;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      row_q      <= row_d;
      cand_col_q <= cand_col_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign row_out   = RowPat[row_q];
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per row slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, consecutive stable slot samples required for press or release.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port col_in  input  4  matrix columns, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port row_out  output  4  matrix row drive, one-hot-low.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse per accepted key press.
REQ-008 SHALL have port key_code  output  4  raw key index, row_idx*4 + col_idx, valid from key_valid onward.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass col_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 SHALL generate a tick on the last cycle of each SCAN_DIV-cycle slot; the slot counter wraps SCAN_DIV-1 -> 0.
REQ-012 SHALL sample the synchronized columns only on tick.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: on tick with no column low, row_out SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 SCAN: on tick with any column low, SHALL latch candidate {row_idx, col_idx}, freeze row_out, clear the stable counter, and go to DEBOUNCE.
REQ-016 When several columns are low, the lowest col_idx SHALL win.
REQ-017 DEBOUNCE: on tick, same candidate column low -> stable counter +1; other or no column -> return to SCAN and advance row_out one step.
REQ-018 DEBOUNCE: when the stable counter reaches DEBOUNCE_TICKS-1, SHALL load key_code, assert key_valid for exactly one cycle, set key_held, and go to HELD.
REQ-019 HELD: on tick with candidate column high, SHALL go to RELEASE with the idle counter at 1; otherwise stay.
REQ-020 RELEASE: on tick with candidate column high, idle counter +1; column low -> back to HELD with no new key_valid.
REQ-021 RELEASE: when the idle counter reaches DEBOUNCE_TICKS, SHALL clear key_held, go to SCAN, and resume rotation from the next row.
REQ-022 key_valid SHALL fire at most once per press-release cycle; key_code SHALL hold its last value until the next accepted press.
REQ-023 Other keys pressed while in HELD or RELEASE SHALL be ignored.

Reset
REQ-024 On rst_n low, SHALL immediately set row_out=1110, key_valid=0, key_code=0, key_held=0, state=SCAN, and zero all counters and synchronizer flops.
REQ-025 Reset mid-DEBOUNCE or mid-HELD SHALL produce no key_valid pulse; scanning restarts at row 0 on the first tick after release.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding, row-pattern constants, and the raw-index-to-hex-digit keymap constant used by calculator operand entry.
REQ-027 SHALL contain one sub-module, sync2, the 2-flop synchronizer; the rest is flat.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-028 Hold row2/col1 low steadily -> one key_valid pulse 2 ticks after detection, key_code=9, key_held=1.
REQ-029 Press row3/col0 for 1 tick only -> no key_valid, row_out resumes rotation to 1110.
REQ-030 Hold key 20 ticks, then release -> exactly one key_valid; key_held falls on the 3rd idle tick; rotation resumes.
REQ-031 On row1, cols 0 and 3 low together -> key_code=4.
REQ-032 In HELD, 1 idle tick then re-press -> key_held stays 1, no second key_valid.
REQ-033 rst_n pulsed low during DEBOUNCE -> all outputs at reset values immediately, no key_valid pulse.
